// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scancode sequencing controller.
package ps2_pkg;

   localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_POP    = 2'd1,
      S_SETTLE = 2'd2,
      S_EVT    = 2'd3
   } ps2_state_t;

   // One key event as presented to the consumer.
   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
   } ps2_evt_t;

   function automatic logic is_prefix(input logic [7:0] b);
      return (b == PS2_PFX_EXT) || (b == PS2_PFX_BRK);
   endfunction

endpackage

// File: rtl/ps2_pfx_timer.sv
// Ages a pending E0/F0 prefix; expire pulses when it has waited too long.
module ps2_pfx_timer #(
   parameter int unsigned PFX_TIMEOUT = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic expire
);

   localparam int unsigned CW = (PFX_TIMEOUT > 1) ? $clog2(PFX_TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(PFX_TIMEOUT - 1);

   logic [CW-1:0] cnt;

   assign expire = run && (cnt == LAST);

   // Count idle cycles with a prefix pending; restart on every byte latch.
   always_ff @(posedge clk) begin
      if (rst || clr || expire) cnt <= '0;
      else if (run)             cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/ps2_scan_ctrl.sv
// Drains the PS/2 receiver FIFO, folds E0/F0 prefixes into key events,
// suppresses typematic repeats and tracks the held key and press count.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for a FIFO byte; ages a pending prefix
// S_POP    | pop strobe low; parse the latched byte
// S_SETTLE | pop strobe high for one cycle so FIFO ready can update
// S_EVT    | event presented, waiting for consumer ack (no FIFO pops)
module ps2_scan_ctrl
   import ps2_pkg::*;
#(
   parameter int          CNT_W           = 8,
   parameter int          SUPPRESS_REPEAT = 1,
   parameter int unsigned PFX_TIMEOUT     = 1000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       kb_data,
   input  logic             kb_ready,
   input  logic             kb_overflow,
   output logic             kb_nextdata_n,
   output logic             evt_valid,
   output logic [7:0]       evt_code,
   output logic             evt_ext,
   output logic             evt_break,
   input  logic             evt_ack,
   output logic             key_held,
   output logic [7:0]       held_code,
   output logic             held_ext,
   output logic [CNT_W-1:0] press_cnt,
   output logic             err_ovf
);

   ps2_state_t state;
   logic [7:0] byte_r;
   logic       ext_f;
   logic       brk_f;
   ps2_evt_t   evt_r;
   logic       held_match;
   logic       tmr_run;
   logic       tmr_clr;
   logic       tmr_expire;

   assign held_match = key_held && (held_code == byte_r) && (held_ext == ext_f);
   assign tmr_clr    = (state == S_IDLE) && kb_ready;
   assign tmr_run    = (state == S_IDLE) && !kb_ready && (ext_f || brk_f);

   assign evt_code   = evt_r.code;
   assign evt_ext    = evt_r.ext;
   assign evt_break  = evt_r.brk;

   ps2_pfx_timer #(.PFX_TIMEOUT(PFX_TIMEOUT)) u_pfx_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (tmr_clr),
      .run    (tmr_run),
      .expire (tmr_expire)
   );

   // Sequencer: byte fetch, prefix parse, event handshake and held-key tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         byte_r        <= '0;
         ext_f         <= 1'b0;
         brk_f         <= 1'b0;
         kb_nextdata_n <= 1'b1;
         evt_r         <= '0;
         evt_valid     <= 1'b0;
         key_held      <= 1'b0;
         held_code     <= '0;
         held_ext      <= 1'b0;
         press_cnt     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (kb_ready) begin
                  byte_r        <= kb_data;
                  kb_nextdata_n <= 1'b0;
                  state         <= S_POP;
               end else if (tmr_expire) begin
                  ext_f <= 1'b0;
                  brk_f <= 1'b0;
               end
            end
            S_POP: begin
               kb_nextdata_n <= 1'b1;
               if (byte_r == PS2_PFX_EXT) begin
                  ext_f <= 1'b1;
                  state <= S_SETTLE;
               end else if (byte_r == PS2_PFX_BRK) begin
                  brk_f <= 1'b1;
                  state <= S_SETTLE;
               end else begin
                  ext_f <= 1'b0;
                  brk_f <= 1'b0;
                  if (brk_f) begin
                     evt_r     <= '{code: byte_r, ext: ext_f, brk: 1'b1};
                     evt_valid <= 1'b1;
                     state     <= S_EVT;
                     // Releasing some other key leaves the held key alone.
                     if (held_match) key_held <= 1'b0;
                  end else if ((SUPPRESS_REPEAT != 0) && held_match) begin
                     state <= S_SETTLE;
                  end else begin
                     evt_r     <= '{code: byte_r, ext: ext_f, brk: 1'b0};
                     evt_valid <= 1'b1;
                     key_held  <= 1'b1;
                     held_code <= byte_r;
                     held_ext  <= ext_f;
                     press_cnt <= press_cnt + 1'b1;
                     state     <= S_EVT;
                  end
               end
            end
            S_SETTLE: state <= S_IDLE;
            S_EVT: begin
               if (evt_ack) begin
                  evt_valid <= 1'b0;
                  state     <= S_SETTLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Sticky FIFO overflow flag; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst)              err_ovf <= 1'b0;
      else if (kb_overflow) err_ovf <= 1'b1;
   end

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Bench: two controllers (repeat suppression on / off) fed the same byte
// stream from modelled FIFOs, checked against a scancode-level event model.
module tb_ps2_scan_ctrl;

   localparam int TMO = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       kb_overflow = 1'b0;
   logic       evt_ack = 1'b0;
   logic [7:0] kb_data [2];
   logic [1:0] kb_ready;
   logic [1:0] kb_nextdata_n, evt_valid, evt_ext, evt_break, key_held, held_ext, err_ovf;
   logic [7:0] evt_code [2];
   logic [7:0] held_code [2];
   logic [7:0] press_cnt [2];

   always #5 clk = ~clk;

   ps2_scan_ctrl #(.CNT_W(8), .SUPPRESS_REPEAT(1), .PFX_TIMEOUT(TMO)) dut_sr1 (
      .clk(clk), .rst(rst), .kb_data(kb_data[0]), .kb_ready(kb_ready[0]),
      .kb_overflow(kb_overflow), .kb_nextdata_n(kb_nextdata_n[0]),
      .evt_valid(evt_valid[0]), .evt_code(evt_code[0]), .evt_ext(evt_ext[0]),
      .evt_break(evt_break[0]), .evt_ack(evt_ack), .key_held(key_held[0]),
      .held_code(held_code[0]), .held_ext(held_ext[0]), .press_cnt(press_cnt[0]),
      .err_ovf(err_ovf[0]));

   ps2_scan_ctrl #(.CNT_W(8), .SUPPRESS_REPEAT(0), .PFX_TIMEOUT(TMO)) dut_sr0 (
      .clk(clk), .rst(rst), .kb_data(kb_data[1]), .kb_ready(kb_ready[1]),
      .kb_overflow(kb_overflow), .kb_nextdata_n(kb_nextdata_n[1]),
      .evt_valid(evt_valid[1]), .evt_code(evt_code[1]), .evt_ext(evt_ext[1]),
      .evt_break(evt_break[1]), .evt_ack(evt_ack), .key_held(key_held[1]),
      .held_code(held_code[1]), .held_ext(held_ext[1]), .press_cnt(press_cnt[1]),
      .err_ovf(err_ovf[1]));

   typedef struct {
      logic [7:0] code;
      logic       ext;
      logic       brk;
      logic       held;
      logic [7:0] hcode;
      logic       hext;
      logic [7:0] cnt;
   } exp_t;

   int n_err = 0;
   int n_chk = 0;
   int n_pushed = 0;
   int pops [2];

   logic [7:0] q0 [$];
   logic [7:0] q1 [$];
   exp_t       exp0 [$];
   exp_t       exp1 [$];

   // Scancode-level model state, one copy per DUT.
   logic       m_ext [2];
   logic       m_brk [2];
   logic       m_held [2];
   logic [7:0] m_hcode [2];
   logic       m_hext [2];
   logic [7:0] m_cnt [2];

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_ext[i] = 0; m_brk[i] = 0; m_held[i] = 0;
         m_hcode[i] = 0; m_hext[i] = 0; m_cnt[i] = 0;
      end
      exp0.delete(); exp1.delete();
   endtask

   // DUT 0 suppresses repeats, DUT 1 does not.
   task automatic model_step(input int i, input logic [7:0] b);
      exp_t e;
      logic match;
      if (b == 8'hE0) m_ext[i] = 1'b1;
      else if (b == 8'hF0) m_brk[i] = 1'b1;
      else begin
         match = m_held[i] && (m_hcode[i] == b) && (m_hext[i] == m_ext[i]);
         e.code = b; e.ext = m_ext[i]; e.brk = m_brk[i];
         if (m_brk[i] || !(i == 0 && match)) begin
            if (m_brk[i]) begin
               if (match) m_held[i] = 1'b0;
            end else begin
               m_held[i] = 1'b1; m_hcode[i] = b; m_hext[i] = m_ext[i];
               m_cnt[i] = m_cnt[i] + 8'd1;
            end
            e.held = m_held[i]; e.hcode = m_hcode[i]; e.hext = m_hext[i]; e.cnt = m_cnt[i];
            if (i == 0) exp0.push_back(e);
            else        exp1.push_back(e);
         end
         m_ext[i] = 1'b0; m_brk[i] = 1'b0;
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      q0.push_back(b); q1.push_back(b);
      n_pushed++;
      model_step(0, b); model_step(1, b);
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input int max_cyc);
      int k = 0;
      while ((q0.size() != 0 || q1.size() != 0 || exp0.size() != 0 || exp1.size() != 0)
             && k < max_cyc) begin
         cyc(1);
         k++;
      end
      cyc(4);
      chk("drain_in_time", (k < max_cyc), 1);
      chk("pops_sr1", pops[0], n_pushed);
      chk("pops_sr0", pops[1], n_pushed);
   endtask

   task automatic wait_valid();
      int k = 0;
      while (!evt_valid[0] && k < 20) begin
         cyc(1);
         k++;
      end
      chk("evt_valid_seen", evt_valid[0], 1);
   endtask

   // FIFO models and the per-cycle compare against the event model.
   logic       prev_v [2];
   logic       prev_acc [2];
   logic       low_prev [2];
   logic [9:0] prev_evt [2];
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            prev_v[i] = 0; prev_acc[i] = 0; low_prev[i] = 0; pops[i] = 0;
         end else begin
            if (!kb_nextdata_n[i]) begin
               pops[i]++;
               chk("pop_single_cycle", low_prev[i], 0);
               if (i == 0 && q0.size() != 0) void'(q0.pop_front());
               if (i == 1 && q1.size() != 0) void'(q1.pop_front());
            end
            low_prev[i] = !kb_nextdata_n[i];
            if (prev_v[i] && !prev_acc[i])
               chk("evt_stable", {evt_valid[i], evt_code[i], evt_ext[i], evt_break[i]},
                   {1'b1, prev_evt[i]});
            if (evt_valid[i] && evt_ack) begin
               if ((i == 0 && exp0.size() == 0) || (i == 1 && exp1.size() == 0)) begin
                  chk("unexpected_event", 1, 0);
               end else begin
                  e = (i == 0) ? exp0.pop_front() : exp1.pop_front();
                  chk("evt_fields", {evt_code[i], evt_ext[i], evt_break[i]},
                      {e.code, e.ext, e.brk});
                  chk("key_held", key_held[i], e.held);
                  if (e.held) chk("held_key", {held_code[i], held_ext[i]}, {e.hcode, e.hext});
                  chk("press_cnt", press_cnt[i], e.cnt);
               end
            end
            prev_v[i]   = evt_valid[i];
            prev_acc[i] = evt_ack;
            prev_evt[i] = {evt_code[i], evt_ext[i], evt_break[i]};
         end
         if (i == 0) begin
            kb_ready[0] = (q0.size() != 0);
            kb_data[0]  = (q0.size() != 0) ? q0[0] : 8'h00;
         end else begin
            kb_ready[1] = (q1.size() != 0);
            kb_data[1]  = (q1.size() != 0) ? q1[0] : 8'h00;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int p0, p1, k, n, base;
      model_reset();
      rst = 1'b1;
      cyc(2);
      for (int i = 0; i < 2; i++) begin
         chk("rst_nextdata_n", kb_nextdata_n[i], 1);
         chk("rst_evt_valid", evt_valid[i], 0);
         chk("rst_press_cnt", press_cnt[i], 0);
         chk("rst_key_held", key_held[i], 0);
         chk("rst_err_ovf", err_ovf[i], 0);
      end
      rst = 1'b0;
      evt_ack = 1'b1;
      cyc(1);

      // Plain press then release.
      push_byte(8'h1C); push_byte(8'hF0); push_byte(8'h1C);
      drain(100);
      chk("make_break_cnt", press_cnt[0], 1);
      chk("make_break_pops", pops[0], 3);
      chk("make_break_held", key_held[0], 0);

      // Extended key press and release.
      push_byte(8'hE0); push_byte(8'h75);
      drain(100);
      chk("ext_held", {key_held[0], held_code[0], held_ext[0]}, {1'b1, 8'h75, 1'b1});
      push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h75);
      drain(100);
      chk("ext_released", key_held[0], 0);
      chk("ext_cnt", press_cnt[0], 2);

      // Typematic repeat.
      base = pops[0];
      push_byte(8'h1C); push_byte(8'h1C); push_byte(8'h1C);
      drain(100);
      chk("repeat_pops", pops[0] - base, 3);
      chk("repeat_cnt_sr1", press_cnt[0], 3);
      chk("repeat_cnt_sr0", press_cnt[1], 5);
      push_byte(8'hF0); push_byte(8'h1C);
      drain(100);

      // Backpressure with the FIFO holding more bytes.
      evt_ack = 1'b0;
      push_byte(8'h2A); push_byte(8'hF0); push_byte(8'h2A);
      wait_valid();
      p0 = pops[0]; p1 = pops[1];
      cyc(50);
      chk("stall_no_pop_sr1", pops[0], p0);
      chk("stall_no_pop_sr0", pops[1], p1);
      chk("stall_ready", kb_ready[0], 1);
      chk("stall_code", evt_code[0], 8'h2A);
      evt_ack = 1'b1;
      k = 0;
      while (pops[0] == p0 && k < 8) begin
         cyc(1);
         k++;
      end
      // Handshake edge, settle, idle latch, then the pop cycle.
      chk("resume_latency", (k <= 4), 1);
      drain(100);

      // Prefix timeout: stale F0 must not turn the next make into a break.
      push_byte(8'hF0);
      drain(100);
      cyc(TMO + 4);
      m_brk[0] = 1'b0; m_brk[1] = 1'b0;
      m_ext[0] = 1'b0; m_ext[1] = 1'b0;
      push_byte(8'h1C);
      drain(100);
      chk("timeout_press", {key_held[0], held_code[0]}, {1'b1, 8'h1C});
      push_byte(8'hF0);
      cyc(5);
      push_byte(8'h1C);
      drain(100);
      chk("no_timeout_release", key_held[0], 0);

      // Press counter wrap.
      n = 255 - int'(m_cnt[0]);
      for (int j = 0; j < n; j++) push_byte((j % 2) ? 8'h10 : 8'h11);
      drain(n * 6 + 100);
      chk("cnt_at_max", press_cnt[0], 255);
      push_byte(8'h12);
      drain(100);
      chk("cnt_wrapped", press_cnt[0], 0);

      // Sticky overflow.
      chk("ovf_before", err_ovf, 2'b00);
      kb_overflow = 1'b1;
      cyc(1);
      kb_overflow = 1'b0;
      cyc(1);
      chk("ovf_set", err_ovf, 2'b11);
      cyc(10);
      chk("ovf_sticky", err_ovf, 2'b11);

      // Reset while an event is pending.
      evt_ack = 1'b0;
      push_byte(8'h1C);
      wait_valid();
      rst = 1'b1;
      q0.delete(); q1.delete();
      model_reset();
      n_pushed = 0;
      cyc(2);
      for (int i = 0; i < 2; i++) begin
         chk("midrst_evt_valid", evt_valid[i], 0);
         chk("midrst_nextdata_n", kb_nextdata_n[i], 1);
         chk("midrst_press_cnt", press_cnt[i], 0);
         chk("midrst_key_held", key_held[i], 0);
         chk("midrst_err_ovf", err_ovf[i], 0);
      end
      rst = 1'b0;
      evt_ack = 1'b1;
      cyc(1);
      push_byte(8'h33);
      drain(100);
      chk("post_rst_cnt", press_cnt[0], 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ps2_scan_ctrl.md
Name: ps2_scan_ctrl

Overview:
- Sequencing controller between the PS/2 receiver FIFO (data/ready/nextdata_n/overflow handshake) and the display/consumer logic.
- Drains the FIFO one byte at a time and parses multi-byte scancode sequences (E0 extended prefix, F0 break prefix) into single key events.
- Suppresses typematic repeats, tracks the currently held key and counts key presses.
- Presents each event on a valid/ack handshake, so a slow consumer back-pressures into the FIFO instead of losing codes.

Parameters:
- CNT_W, 8, width of press counter (wraps modulo 2^CNT_W)
- SUPPRESS_REPEAT, 1, 1 = repeated make of the held key produces no event
- PFX_TIMEOUT, 1000000, cycles a pending E0/F0 prefix survives without a following byte

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- kb_data  in  8  FIFO head byte; valid while kb_ready=1
- kb_ready  in  1  FIFO non-empty
- kb_overflow  in  1  FIFO overflow indication
- kb_nextdata_n  out  1  active-low pop; low for exactly one cycle per byte consumed
- evt_valid  out  1  event available
- evt_code  out  8  scancode of event (prefixes stripped)
- evt_ext  out  1  event had E0 prefix
- evt_break  out  1  1 = release, 0 = press
- evt_ack  in  1  consumer accepts event (transfer when evt_valid & evt_ack)
- key_held  out  1  a key is currently held
- held_code  out  8  code of held key (valid when key_held)
- held_ext  out  1  ext flag of held key
- press_cnt  out  CNT_W  count of accepted press events
- err_ovf  out  1  sticky; set when kb_overflow seen

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0 except kb_nextdata_n=1. FSM in S_IDLE, prefix flags cleared, timeout counter 0. Reset mid-sequence drops any partial prefix and any pending event.
- FSM states: S_IDLE, S_POP, S_SETTLE, S_EVT.
- S_IDLE: if kb_ready=1, latch kb_data into byte_r and go to S_POP.
- S_POP: kb_nextdata_n=0 for this single cycle. Parse byte_r:
  - 0xE0: set ext_f, go to S_SETTLE.
  - 0xF0: set brk_f, go to S_SETTLE.
  - Other, break (brk_f=1): build event {byte_r, ext_f, brk=1}. If key_held and held_code==byte_r and held_ext==ext_f, clear key_held. Go to S_EVT.
  - Other, make, repeat (SUPPRESS_REPEAT=1 and key_held and held_code/held_ext match): no event. Clear flags, go to S_SETTLE.
  - Other, make, new key: build event, set key_held, held_code, held_ext, increment press_cnt. Go to S_EVT.
  - Whenever an event is built, ext_f and brk_f are cleared.
- S_SETTLE: one cycle with kb_nextdata_n=1 so the FIFO's ready updates; then go to S_IDLE. The minimum byte period is therefore 3 cycles.
- S_EVT: evt_valid=1 with fields stable. On evt_ack, drop evt_valid the next cycle and go to S_SETTLE. No FIFO pop occurs while in S_EVT (backpressure).
- press_cnt counts presses at parse time (not at ack), wraps from max to 0. Releases and suppressed repeats never increment it.
- A new press while a different key is held replaces held_code/held_ext; key_held stays 1.
- A release of a non-held key emits an event but leaves key_held unchanged.
- Prefix timeout: while ext_f or brk_f is set in S_IDLE with kb_ready=0, a counter increments. When it reaches PFX_TIMEOUT-1, both flags clear and the counter resets. The counter resets on every byte latch.
- Consecutive prefixes: E0 then F0 gives ext_f=brk_f=1. A duplicate F0 leaves brk_f=1.
- err_ovf is set when kb_overflow=1 in any cycle and cleared only by reset; parsing continues.
- Simultaneous kb_ready and evt_ack in S_EVT: ack is handled first; the FIFO byte is taken on the S_IDLE visit 2 cycles later.

Decomposition:
- Shared package (ps2_pkg) holds:
  - constants PS2_PFX_EXT=8'hE0 and PS2_PFX_BRK=8'hF0
  - state enum/localparams for S_IDLE/S_POP/S_SETTLE/S_EVT
  - event field layout
- One sub-module: ps2_pfx_timer (prefix timeout counter with clear/expire). The rest of the block stays flat.

Test Plan:
- Reset: hold rst 2 cycles mid-S_EVT -> evt_valid=0, kb_nextdata_n=1, press_cnt=0, key_held=0, err_ovf=0.
- Bytes 1C, F0, 1C with evt_ack tied 1 -> event {1C, ext0, brk0}, then {1C, ext0, brk1}; press_cnt=1; key_held 1 then 0; exactly three single-cycle kb_nextdata_n pulses.
- Bytes E0 75, E0 F0 75 -> events {75, ext1, brk0} and {75, ext1, brk1}; held_ext=1 while held.
- Bytes 1C 1C 1C (repeat), SUPPRESS_REPEAT=1 -> one event, press_cnt=1, three pops. With SUPPRESS_REPEAT=0 -> three events, press_cnt=3.
- Backpressure: evt_ack=0 for 50 cycles with kb_ready=1 -> no kb_nextdata_n pulse during the stall, evt_code stable; on ack, next byte is consumed within 3 cycles.
- Byte F0, then idle for PFX_TIMEOUT cycles (bench sets PFX_TIMEOUT=16), then 1C -> press event, not release. Plus: press_cnt at 255 with CNT_W=8, one more press -> press_cnt=0. Plus: kb_overflow pulsed 1 cycle -> err_ovf=1 until reset.
